mem_access_stage: RTL

//  MEM stage of the 5-stage CPU. It accepts the EXE->MEM bundle and issues store/load transactions on the SRAM-like data port.
//  It realigns returned load data (LB/LBU/LH/LHU/LW/LWL/LWR), merges LWL/LWR with the old rt value and presents the MEM->WB bundle.
//  It is the consumer of the byte strobes, aligned store data and load flags produced upstream.

---
 rtl/mem_access_stage_pkg.sv | 18 +
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage_load_align.sv | 55 +++++
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: LW-family selector and the stage FSM states.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        LW_NONE = 2'b00,
        LW_LWR  = 2'b01,
        LW_LWL  = 2'b10,
        LW_WORD = 2'b11
    } lw_kind_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// SRAM-like data port between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Combinational load realignment: sub-word extract/extend and LWL/LWR merge with old rt.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  i_v,
    input  logic [31:0] i_m,
    input  logic [31:0] i_r,
    input  logic        i_LB,
    input  logic        i_LBU,
    input  logic        i_LH,
    input  logic        i_LHU,
    input  lw_kind_e    i_LW,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_v)
            2'd0:    w_byte = i_m[7:0];
            2'd1:    w_byte = i_m[15:8];
            2'd2:    w_byte = i_m[23:16];
            default: w_byte = i_m[31:24];
        endcase
        w_half   = i_v[1] ? i_m[31:16] : i_m[15:0];
        o_result = i_m;
        case (i_LW)
            LW_LWL: begin
                case (i_v)
                    2'd0:    o_result = {i_m[7:0],  i_r[23:0]};
                    2'd1:    o_result = {i_m[15:0], i_r[15:0]};
                    2'd2:    o_result = {i_m[23:0], i_r[7:0]};
                    default: o_result = i_m;
                endcase
            end
            LW_LWR: begin
                case (i_v)
                    2'd0:    o_result = i_m;
                    2'd1:    o_result = {i_r[31:24], i_m[31:8]};
                    2'd2:    o_result = {i_r[31:16], i_m[31:16]};
                    default: o_result = {i_r[31:8],  i_m[31:24]};
                endcase
            end
            LW_WORD: o_result = i_m;
            default: begin
                if (i_LB)       o_result = {{24{w_byte[7]}}, w_byte};
                else if (i_LBU) o_result = {24'd0, w_byte};
                else if (i_LH)  o_result = {{16{w_half[15]}}, w_half};
                else if (i_LHU) o_result = {16'd0, w_half};
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: latches the EXE bundle, runs the data-port transaction and hands the
// writeback bundle to WB.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_exe_valid,
    input  logic               i_ex_int_handle,
    output logic               o_mem_allowin,
    input  logic               i_MemEn,
    input  logic               i_MemToReg,
    input  logic [3:0]         i_MemWrite,
    input  logic               i_LB,
    input  logic               i_LBU,
    input  logic               i_LH,
    input  logic               i_LHU,
    input  logic [1:0]         i_LW,
    input  logic [3:0]         i_RegWrite,
    input  logic [4:0]         i_RegWaddr,
    input  logic [31:0]        i_ALUResult,
    input  logic [31:0]        i_MemWdata,
    input  logic [31:0]        i_RegRdata2,
    input  logic [31:0]        i_PC,
    mem_access_stage_if.master dbus,
    input  logic               i_wb_allowin,
    output logic               o_wb_valid,
    output logic [31:0]        o_RegWdata_MEM_WB,
    output logic [3:0]         o_RegWrite_MEM_WB,
    output logic [4:0]         o_RegWaddr_MEM_WB,
    output logic [31:0]        o_PC_MEM_WB,
    output logic [31:0]        o_Bypass_MEM,
    output logic               o_load_pending
);

    mem_state_e  r_state;
    logic        r_memtoreg;
    logic [3:0]  r_memwrite;
    logic        r_lb, r_lbu, r_lh, r_lhu;
    lw_kind_e    r_lw;
    logic [3:0]  r_regwrite;
    logic [4:0]  r_regwaddr;
    logic [31:0] r_alu;
    logic [31:0] r_wdata;
    logic [31:0] r_rt;
    logic [31:0] r_pc;
    logic [31:0] r_regwdata;
    logic        r_data_req;
    logic        r_wb_valid;

    logic        w_accept;
    logic [31:0] w_load_res;

    assign o_mem_allowin = (r_state == S_IDLE) || (r_state == S_DONE && i_wb_allowin);
    assign w_accept      = i_exe_valid && o_mem_allowin;

    mem_access_stage_load_align u_load_align (
        .i_v      (r_alu[1:0]),
        .i_m      (dbus.data_rdata),
        .i_r      (r_rt),
        .i_LB     (r_lb),
        .i_LBU    (r_lbu),
        .i_LH     (r_lh),
        .i_LHU    (r_lhu),
        .i_LW     (r_lw),
        .o_result (w_load_res)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_memtoreg <= 1'b0;
            r_memwrite <= '0;
            r_lb       <= 1'b0;
            r_lbu      <= 1'b0;
            r_lh       <= 1'b0;
            r_lhu      <= 1'b0;
            r_lw       <= LW_NONE;
            r_regwrite <= '0;
            r_regwaddr <= '0;
            r_alu      <= '0;
            r_wdata    <= '0;
            r_rt       <= '0;
            r_pc       <= '0;
            r_regwdata <= '0;
            r_data_req <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: if (dbus.data_addr_ok) begin
                    r_data_req <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: if (dbus.data_data_ok) begin
                    if (r_memtoreg) r_regwdata <= w_load_res;
                    r_wb_valid <= 1'b1;
                    r_state    <= S_DONE;
                end
                default: ;
            endcase
            // Accept only happens in IDLE/DONE, so it never collides with the REQ/WAIT arms.
            if (w_accept) begin
                r_wb_valid <= 1'b0;
                r_state    <= S_IDLE;
                if (!i_ex_int_handle) begin
                    r_memtoreg <= i_MemToReg;
                    r_memwrite <= i_MemWrite;
                    r_lb       <= i_LB;
                    r_lbu      <= i_LBU;
                    r_lh       <= i_LH;
                    r_lhu      <= i_LHU;
                    r_lw       <= lw_kind_e'(i_LW);
                    r_regwrite <= i_RegWrite;
                    r_regwaddr <= i_RegWaddr;
                    r_alu      <= i_ALUResult;
                    r_wdata    <= i_MemWdata;
                    r_rt       <= i_RegRdata2;
                    r_pc       <= i_PC;
                    r_regwdata <= i_ALUResult;
                    if (i_MemEn) begin
                        r_data_req <= 1'b1;
                        r_state    <= S_REQ;
                    end else begin
                        r_wb_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
            end else if (r_state == S_DONE && i_wb_allowin) begin
                r_wb_valid <= 1'b0;
                r_state    <= S_IDLE;
            end
        end
    end

    assign dbus.data_req    = r_data_req;
    assign dbus.data_wr     = |r_memwrite;
    assign dbus.data_wstrb  = r_memwrite;
    assign dbus.data_addr   = {r_alu[31:2], 2'b00};
    assign dbus.data_wdata  = r_wdata;

    assign o_wb_valid        = r_wb_valid;
    assign o_RegWdata_MEM_WB = r_regwdata;
    assign o_RegWrite_MEM_WB = r_wb_valid ? r_regwrite : '0;
    assign o_RegWaddr_MEM_WB = r_regwaddr;
    assign o_PC_MEM_WB       = r_pc;
    assign o_Bypass_MEM      = (r_state == S_DONE) ? r_regwdata : r_alu;
    assign o_load_pending    = (r_state == S_REQ || r_state == S_WAIT) && r_memtoreg;

endmodule
